// File: rtl/sccb_init_sequencer.sv
// Replays a pROM init table to an OV5640 as SCCB 3-phase writes and flags completion.
// Build macro SCCB_ACK_CHECK_EN: a high ACK sample aborts the run with STOP and err=1.
module sccb_init_sequencer #(
  parameter int unsigned CLK_HZ       = 27000000,
  parameter int unsigned SCCB_HZ      = 100000,
  parameter logic [7:0]  DEV_ADDR     = 8'h78,
  parameter int unsigned PWRUP_CYCLES = 540000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [8:0]  rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [15:0] rom_dout,
  output logic        sccb_scl,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  wr_count
);

  // state   | meaning
  // IDLE    | after reset, waiting for start
  // PWRUP   | sensor power-up delay
  // FETCH_A | register address word addressed
  // FETCH_D | latch address, then latch data word
  // START   | SCCB start condition
  // BYTE    | one data bit per slot, MSB first
  // ACK     | ninth bit slot, SDA released
  // STOP    | SCCB stop condition
  // GAP     | bus idle between writes
  // FIN     | sequence finished, waiting for restart
  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH_A, FETCH_D, START, BYTE, ACK, STOP, GAP, FIN
  } state_t;

  localparam int unsigned QTR_DIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned QTR     = (QTR_DIV < 1) ? 1 : QTR_DIV;
  localparam int unsigned QW      = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned PW      = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LOAD  = QW'(QTR - 1);
  localparam logic [PW-1:0] PW_LOAD = PW'(PWRUP_CYCLES - 1);

`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [PW-1:0] pw_cnt;
  logic [7:0]    n;
  logic [15:0]   reg_addr;
  logic [7:0]    data;
  logic          fetch_ph;
  logic          nack;
  logic          scl_c, sda_c;
  logic          q_end, slot_end, bus_st;
  logic          clear_run, gap_end, set_done, set_err;
  logic [7:0]    byte_val;
  logic          bit_val;

  assign q_end    = (qcnt == '0);
  assign slot_end = q_end && (q == 2'd3);
  assign bus_st   = (state == START) || (state == BYTE) || (state == ACK) ||
                    (state == STOP)  || (state == GAP);

  assign rom_ad  = {n, (state == FETCH_D)};
  assign rom_ce  = (state == FETCH_A) || (state == FETCH_D);
  assign rom_oce = 1'b1;
  assign busy    = (state != IDLE) && (state != FIN);

  always_comb begin
    byte_val = DEV_ADDR;
    case (byte_idx)
      2'd1:    byte_val = reg_addr[15:8];
      2'd2:    byte_val = reg_addr[7:0];
      2'd3:    byte_val = data;
      default: byte_val = DEV_ADDR;
    endcase
  end

  assign bit_val = byte_val[3'd7 - bit_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_c     = 1'b1;
    sda_c     = 1'b0;
    clear_run = 1'b0;
    gap_end   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          clear_run = 1'b1;
          state_nxt = (PWRUP_CYCLES == 0) ? FETCH_A : PWRUP;
        end
      end
      PWRUP:   if (pw_cnt == '0) state_nxt = FETCH_A;
      FETCH_A: state_nxt = FETCH_D;
      FETCH_D: begin
        if (fetch_ph) begin
          if (reg_addr == 16'hFFFF) begin
            state_nxt = FIN;
            set_done  = 1'b1;
          end else begin
            state_nxt = START;
          end
        end
      end
      START: begin
        scl_c = !q[1];
        sda_c = (q != 2'd0);
        if (slot_end) state_nxt = BYTE;
      end
      BYTE: begin
        scl_c = q[1];
        sda_c = !bit_val;
        if (slot_end && (bit_idx == 3'd7)) state_nxt = ACK;
      end
      ACK: begin
        scl_c = q[1];
        if (slot_end) state_nxt = (nack || (byte_idx == 2'd3)) ? STOP : BYTE;
      end
      STOP: begin
        scl_c = (q != 2'd0);
        sda_c = !q[1];
        if (slot_end) begin
          if (nack) begin
            state_nxt = FIN;
            set_done  = 1'b1;
            set_err   = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (slot_end) begin
          gap_end = 1'b1;
          // 256 entries without a terminator is treated as a corrupt table
          if (n == 8'hFF) begin
            state_nxt = FIN;
            set_done  = 1'b1;
            set_err   = 1'b1;
          end else begin
            state_nxt = FETCH_A;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt        <= Q_LOAD;
      q           <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      pw_cnt      <= '0;
      n           <= '0;
      reg_addr    <= '0;
      data        <= '0;
      fetch_ph    <= 1'b0;
      nack        <= 1'b0;
      sccb_scl    <= 1'b1;
      sccb_sda_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_count    <= '0;
    end else begin
      // pins are registered so the bus never sees decode glitches
      sccb_scl    <= scl_c;
      sccb_sda_oe <= sda_c;
      if (!bus_st) begin
        qcnt <= Q_LOAD;
        q    <= '0;
      end else if (q_end) begin
        qcnt <= Q_LOAD;
        q    <= q + 2'd1;
      end else begin
        qcnt <= qcnt - QW'(1);
      end
      if ((state == BYTE) && slot_end) bit_idx  <= bit_idx + 3'd1;
      if ((state == ACK) && slot_end)  byte_idx <= byte_idx + 2'd1;
      if (state == FETCH_A) begin
        fetch_ph <= 1'b0;
        nack     <= 1'b0;
        bit_idx  <= '0;
        byte_idx <= '0;
      end
      if (state == FETCH_D) begin
        fetch_ph <= 1'b1;
        if (!fetch_ph) reg_addr <= rom_dout;
        else           data     <= rom_dout[7:0];
      end
      if ((state == ACK) && (q == 2'd2) && q_end && ACK_CHECK && sccb_sda_i) nack <= 1'b1;
      if (clear_run) begin
        pw_cnt   <= PW_LOAD;
        n        <= '0;
        wr_count <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
      end else if (state == PWRUP) begin
        pw_cnt <= pw_cnt - PW'(1);
      end
      if (gap_end) begin
        if (n != 8'hFF)        n        <= n + 8'd1;
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end
      if (set_done) done <= 1'b1;
      if (set_err)  err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: random init tables, a pROM model and an SCCB bus decoder/slave.
// A second instance with one-cycle quarters covers the 256-entry overrun and power-up delay.
`timescale 1ns/1ps
module tb_sccb_init_sequencer;

  localparam logic [7:0] DEV = 8'h78;
  localparam int QTR     = 10;
  localparam int WR_CYC  = 156 * QTR + 3;
  localparam int F_PWRUP = 5;
  localparam int F_WR    = 156 + 3;

  logic clk = 1'b0;
  logic reset;
  logic start, start_f;
  logic [8:0]  rom_ad, rom_ad_f;
  logic        rom_ce, rom_ce_f, rom_oce, rom_oce_f;
  logic [15:0] rom_dout = '0;
  logic [15:0] rom_dout_f = '0;
  logic scl, sda_oe, sda_i, scl_f, sda_oe_f;
  logic busy, done, err, busy_f, done_f, err_f;
  logic [7:0] wr_count, wr_count_f;
  logic slave_pull = 1'b0;

  logic [15:0] rom   [512];
  logic [15:0] rom_f [512];

  int n_checks = 0;
  int n_fail   = 0;

  // bus monitor state
  logic [8:0] busq[$];
  logic [8:0] adq[$];
  logic [8:0] exp_q[$];
  int   ce_cycles, ack_idx, bitcnt;
  int   nack_at = -1;
  logic [7:0] sh;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  int   exp_cyc, exp_wr, exp_fetch;
  logic exp_err;

  always #5 clk = ~clk;

  assign sda_i = ~(sda_oe | slave_pull);

  sccb_init_sequencer #(
    .CLK_HZ(4000000), .SCCB_HZ(100000), .DEV_ADDR(DEV), .PWRUP_CYCLES(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .sccb_scl(scl), .sccb_sda_oe(sda_oe), .sccb_sda_i(sda_i),
    .busy(busy), .done(done), .err(err), .wr_count(wr_count)
  );

  sccb_init_sequencer #(
    .CLK_HZ(400000), .SCCB_HZ(100000), .DEV_ADDR(DEV), .PWRUP_CYCLES(F_PWRUP)
  ) dut_f (
    .clk(clk), .reset(reset), .start(start_f),
    .rom_ad(rom_ad_f), .rom_ce(rom_ce_f), .rom_oce(rom_oce_f), .rom_dout(rom_dout_f),
    .sccb_scl(scl_f), .sccb_sda_oe(sda_oe_f), .sccb_sda_i(1'b0),
    .busy(busy_f), .done(done_f), .err(err_f), .wr_count(wr_count_f)
  );

  always @(posedge clk) if (rom_ce)   rom_dout   <= rom[rom_ad];
  always @(posedge clk) if (rom_ce_f) rom_dout_f <= rom_f[rom_ad_f];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // decode START/bytes/STOP and ack each byte unless told to withhold one
  always @(negedge clk) begin
    logic c_sda;
    if (reset) begin
      p_scl = 1'b1; p_sda = 1'b1; bitcnt = 0; slave_pull = 1'b0;
    end else begin
      c_sda = ~(sda_oe | slave_pull);
      if (rom_ce) begin
        ce_cycles++;
        if (adq.size() == 0 || adq[$] != rom_ad) adq.push_back(rom_ad);
      end
      if (p_scl && scl && p_sda && !c_sda) begin
        bitcnt = 0;
      end else if (p_scl && scl && !p_sda && c_sda) begin
        busq.push_back(9'h100);
      end else if (!p_scl && scl) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], c_sda};
          bitcnt++;
          if (bitcnt == 8) busq.push_back({1'b0, sh});
        end else begin
          bitcnt = 0;
          ack_idx++;
        end
      end else if (p_scl && !scl) begin
        slave_pull = (bitcnt == 8) && (ack_idx != nack_at);
      end
      p_scl = scl;
      p_sda = c_sda;
    end
  end

  // expected bus bytes, timing and flags straight from the table rules
  task automatic build_model(input int nack_k);
    int w, j, writes;
    bit term;
    logic [15:0] ra;
    logic [7:0] b [4];
    exp_q.delete();
    writes = 0;
    term   = 0;
    w = (nack_k >= 0) ? nack_k / 4 : 1000;
    j = (nack_k >= 0) ? nack_k % 4 : 0;
    for (int e = 0; e < 256; e++) begin
      ra = rom[2*e];
      if (ra == 16'hFFFF) begin
        term = 1;
        break;
      end
      b[0] = DEV; b[1] = ra[15:8]; b[2] = ra[7:0]; b[3] = rom[2*e+1][7:0];
      if (e == w) begin
        for (int k = 0; k <= j; k++) exp_q.push_back({1'b0, b[k]});
        exp_q.push_back(9'h100);
        exp_cyc   = writes * WR_CYC + 3 + (8 + 36 * (j + 1)) * QTR;
        exp_wr    = writes;
        exp_err   = 1'b1;
        exp_fetch = writes + 1;
        return;
      end
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, b[k]});
      exp_q.push_back(9'h100);
      writes++;
    end
    exp_wr    = (writes > 255) ? 255 : writes;
    exp_err   = !term;
    exp_fetch = term ? writes + 1 : 256;
    exp_cyc   = term ? writes * WR_CYC + 3 : 256 * WR_CYC;
  endtask

  task automatic fill_rom(input int entries);
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    for (int e = 0; e < entries; e++) if (rom[2*e] == 16'hFFFF) rom[2*e] = 16'h3008;
    rom[2*entries] = 16'hFFFF;
  endtask

  task automatic launch(input int nack_k);
    @(posedge clk); #1;
    busq.delete(); adq.delete();
    ce_cycles = 0; ack_idx = 0; nack_at = nack_k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int nack_k, input int poke);
    int cyc;
`ifdef SCCB_ACK_CHECK_EN
    build_model(nack_k);
`else
    build_model(-1);
`endif
    launch(nack_k);
    chk({tag, " busy_after_start"}, busy, 1'b1);
    chk({tag, " done_cleared"}, done, 1'b0);
    chk({tag, " wr_cleared"}, wr_count, 8'd0);
    cyc = 0;
    while (!done && cyc < exp_cyc + 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, " done_cycle"}, cyc, exp_cyc);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " wr_count"}, wr_count, exp_wr);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, " done_held"}, done, 1'b1);
    chk({tag, " bus_len"}, busq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < busq.size(); i++)
      chk($sformatf("%s bus[%0d]", tag, i), busq[i], exp_q[i]);
    chk({tag, " rom_ce_cycles"}, ce_cycles, 3 * exp_fetch);
    chk({tag, " rom_ad_len"}, adq.size(), 2 * exp_fetch);
    for (int i = 0; i < adq.size() && i < 2 * exp_fetch; i++)
      chk($sformatf("%s rom_ad[%0d]", tag, i), adq[i], i);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; start_f = 1'b0;
    for (int i = 0; i < 512; i++) begin rom[i] = '0; rom_f[i] = '0; end
    #12;
    chk("rst rom_ad", rom_ad, 9'd0);
    chk("rst rom_ce", rom_ce, 1'b0);
    chk("rst rom_oce", rom_oce, 1'b1);
    chk("rst scl", scl, 1'b1);
    chk("rst sda_oe", sda_oe, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst wr_count", wr_count, 8'd0);
    chk("rst fast scl", scl_f, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    rom[0] = 16'h3103; rom[1] = 16'h0011; rom[2] = 16'h3008; rom[3] = 16'h0082;
    rom[4] = 16'hFFFF;
    run_seq("normal", -1, 0);
    run_seq("replay", -1, 0);

    fill_rom(3);
    run_seq("busy_poke", -1, int'($urandom_range(10, 3000)));

    rom[0] = 16'h3103; rom[1] = 16'h0011; rom[2] = 16'h3008; rom[3] = 16'h0082;
    rom[4] = 16'hFFFF;
    run_seq("nack", 1, 0);

    fill_rom(2);
    launch(-1);
    cyc = 0;
    while (cyc < WR_CYC + 3 + 80 * QTR) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst wr_before", wr_count, 8'd1);
    chk("midrst busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst scl", scl, 1'b1);
    chk("midrst sda_oe", sda_oe, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst wr_count", wr_count, 8'd0);
    chk("midrst rom_ce", rom_ce, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_seq("after_reset", -1, 0);

    for (int i = 0; i < 512; i++) begin
      rom_f[i] = 16'($urandom);
      if (i % 2 == 0 && rom_f[i] == 16'hFFFF) rom_f[i] = 16'h0000;
    end
    @(posedge clk); #1;
    start_f = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    chk("overrun busy", busy_f, 1'b1);
    cyc = 0;
    while (!done_f && cyc < F_PWRUP + 256 * F_WR + 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("overrun done_cycle", cyc, F_PWRUP + 256 * F_WR);
    chk("overrun err", err_f, 1'b1);
    chk("overrun wr_count", wr_count_f, 8'd255);
    chk("overrun busy_end", busy_f, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
